gen_life_cell: RTL and testbench

Parametrised successor to the basic Life cell. It computes the next state of one cellular-automaton cell under a runtime-programmable birth/survive rule, with optional multi-state "Generations" decay and a Moore or von Neumann neighbourhood. It also tracks a saturating per-cell stability age. The block is instantiated once per grid site in the array and keeps the existing write-load and scan-chain features.

---
 rtl/gen_life_cell.sv | 104 ++++++++++
 tb/tb_gen_life_cell.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/gen_life_cell.sv
// gen_life_cell: one site of a cellular-automaton array.
// Computes the next cell state under a programmable birth/survive rule,
// with optional Generations-style decay. It also tracks a saturating
// stability age, a one-cycle change flag, and the write-load and scan-load
// paths.
//
// state value      | meaning
// -----------------+----------------------------------------------
// 0                | dead
// 1                | alive (the only value seen as live by neighbours)
// 2..max_state     | dying, advances by one per step, then dead
// > max_state      | illegal (loaded by write/scan), cleared on next step
module gen_life_cell #(
  parameter int STATE_W = 2,
  parameter int AGE_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [7:0]         nbr,
  input  logic               mode_vn,
  input  logic [8:0]         birth_mask,
  input  logic [8:0]         survive_mask,
  input  logic [STATE_W-1:0] max_state,
  input  logic               enb,
  input  logic               write,
  input  logic [STATE_W-1:0] val,
  input  logic               scan,
  input  logic [STATE_W-1:0] scan_in,
  output logic [STATE_W-1:0] state,
  output logic               alive,
  output logic [AGE_W-1:0]   age,
  output logic               changed
);

  localparam logic [STATE_W-1:0] ONE = STATE_W'(1);

  logic [7:0]         nbr_masked;
  logic [3:0]         cnt;
  logic               multi_state;
  logic [STATE_W-1:0] top_state;
  logic [STATE_W-1:0] nxt;

  // Neighbours with alive=1 only; von Neumann keeps just n/e/s/w.
  always_comb begin
    nbr_masked = mode_vn ? (nbr & 8'h55) : nbr;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, nbr_masked[i]};
    end
  end

  // Next-state rule. A max_state of 0 or 1 behaves as classic two-state Life,
  // so the highest legal value is then 1.
  always_comb begin
    multi_state = (max_state > ONE);
    top_state   = multi_state ? max_state : ONE;
    nxt         = '0;
    if (state > top_state) begin
      nxt = '0;
    end else if (state == '0) begin
      nxt = birth_mask[cnt] ? ONE : '0;
    end else if (state == ONE) begin
      if (survive_mask[cnt]) nxt = ONE;
      else if (multi_state)  nxt = ONE + ONE;
      else                   nxt = '0;
    end else if (state == max_state) begin
      nxt = '0;
    end else begin
      nxt = state + ONE;
    end
  end

  // State, age and change flag; scan beats write beats step beats hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= '0;
      age     <= '0;
      changed <= 1'b0;
    end else if (scan) begin
      state   <= scan_in;
      age     <= '0;
      changed <= 1'b0;
    end else if (write) begin
      state   <= val;
      age     <= '0;
      changed <= 1'b0;
    end else if (enb) begin
      state <= nxt;
      if (nxt == state) begin
        if (age != '1) age <= age + AGE_W'(1);
        changed <= 1'b0;
      end else begin
        age     <= '0;
        changed <= 1'b1;
      end
    end else begin
      changed <= 1'b0;
    end
  end

  // Live indication fed to the neighbouring cells.
  always_comb alive = (state == ONE);

endmodule

// File: tb/tb_gen_life_cell.sv
// Bench for gen_life_cell: directed steps with a scoreboard of expected
// state/age/changed, plus directed spot checks on test-plan outcomes.
module tb_gen_life_cell;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] nbr;
  logic       mode_vn;
  logic [8:0] birth_mask;
  logic [8:0] survive_mask;
  logic [1:0] max_state;
  logic       enb;
  logic       write;
  logic [1:0] val;
  logic       scan;
  logic [1:0] scan_in;
  logic [1:0] state;
  logic       alive;
  logic [3:0] age;
  logic       changed;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] st;
    logic [3:0] ag;
    logic       ch;
  } exp_t;

  exp_t sb[$];

  logic [1:0] m_state;
  logic [3:0] m_age;
  logic       m_changed;

  gen_life_cell #(.STATE_W(2), .AGE_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .nbr(nbr), .mode_vn(mode_vn),
    .birth_mask(birth_mask), .survive_mask(survive_mask),
    .max_state(max_state), .enb(enb), .write(write), .val(val),
    .scan(scan), .scan_in(scan_in), .state(state), .alive(alive),
    .age(age), .changed(changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference rule written straight from the rule description.
  function automatic logic [1:0] rule_next(input logic [1:0] s);
    int c;
    int mx;
    int top;
    int si;
    c  = mode_vn ? $countones(nbr & 8'h55) : $countones(nbr);
    mx = int'(max_state);
    top = (mx >= 2) ? mx : 1;
    si = int'(s);
    if (si > top)      return 2'd0;
    else if (si == 0)  return birth_mask[c] ? 2'd1 : 2'd0;
    else if (si == 1)  return survive_mask[c] ? 2'd1 : ((mx >= 2) ? 2'd2 : 2'd0);
    else if (si == mx) return 2'd0;
    else               return 2'(si + 1);
  endfunction

  // One clock: model the edge, push expectation, clock DUT, pop and compare.
  task automatic cycle(input string tag);
    exp_t e;
    logic [1:0] n;
    if (scan) begin
      m_state = scan_in; m_age = 4'd0; m_changed = 1'b0;
    end else if (write) begin
      m_state = val; m_age = 4'd0; m_changed = 1'b0;
    end else if (enb) begin
      n = rule_next(m_state);
      if (n == m_state) begin
        if (m_age != 4'd15) m_age = m_age + 4'd1;
        m_changed = 1'b0;
      end else begin
        m_age = 4'd0; m_changed = 1'b1;
      end
      m_state = n;
    end else begin
      m_changed = 1'b0;
    end
    e.st = m_state; e.ag = m_age; e.ch = m_changed;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_state"},   state,   e.st);
      check({tag, "_age"},     age,     e.ag);
      check({tag, "_changed"}, changed, e.ch);
      check({tag, "_alive"},   alive,   (e.st == 2'd1));
    end
  endtask

  task automatic idle_ctl();
    enb = 1'b0; write = 1'b0; scan = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; nbr = 8'h00; mode_vn = 1'b0;
    birth_mask = 9'h008; survive_mask = 9'h00C; max_state = 2'd1;
    enb = 1'b0; write = 1'b0; val = 2'd0; scan = 1'b0; scan_in = 2'd0;
    m_state = 2'd0; m_age = 4'd0; m_changed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state, 2'd0);
    check("rst_age", age, 4'd0);
    check("rst_changed", changed, 1'b0);
    check("rst_alive", alive, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Conway B3/S23
    nbr = 8'h07; enb = 1'b1;
    cycle("conway_birth");
    check("conway_birth_is1", state, 2'd1);
    check("conway_birth_chg", changed, 1'b1);
    enb = 1'b0;
    cycle("conway_hold");
    check("conway_chg_oneshot", changed, 1'b0);
    nbr = 8'h0F; enb = 1'b1;
    cycle("conway_death");
    check("conway_death_is0", state, 2'd0);

    // Generations decay, max_state=3, nothing survives
    idle_ctl(); max_state = 2'd3; survive_mask = 9'h000; nbr = 8'h00;
    write = 1'b1; val = 2'd1;
    cycle("gen_load1");
    idle_ctl(); enb = 1'b1;
    cycle("gen_1to2");
    check("gen_s2", state, 2'd2);
    cycle("gen_2to3");
    check("gen_s3", state, 2'd3);
    cycle("gen_3to0");
    check("gen_s0", state, 2'd0);
    idle_ctl(); write = 1'b1; val = 2'd2;
    cycle("gen_load2");
    idle_ctl(); enb = 1'b1; nbr = 8'h07;
    cycle("gen_no_rebirth");
    check("gen_no_rebirth_s3", state, 2'd3);
    cycle("gen_end");
    cycle("gen_rebirth");
    check("gen_rebirth_s1", state, 2'd1);

    // Neighbourhood with B4, diagonals only
    idle_ctl(); birth_mask = 9'h010; max_state = 2'd1; nbr = 8'hAA;
    write = 1'b1; val = 2'd0;
    cycle("nb_clear");
    idle_ctl(); enb = 1'b1; mode_vn = 1'b0;
    cycle("nb_moore");
    check("nb_moore_s1", state, 2'd1);
    idle_ctl(); write = 1'b1; val = 2'd0;
    cycle("nb_clear2");
    idle_ctl(); enb = 1'b1; mode_vn = 1'b1;
    cycle("nb_vn");
    check("nb_vn_s0", state, 2'd0);
    mode_vn = 1'b0;

    // Age saturation on a stable live cell
    idle_ctl(); survive_mask = 9'h1FF; nbr = 8'h00; write = 1'b1; val = 2'd1;
    cycle("age_load");
    idle_ctl(); enb = 1'b1;
    for (int i = 0; i < 20; i++) cycle("age_step");
    check("age_sat", age, 4'd15);
    check("age_nochg", changed, 1'b0);
    idle_ctl(); write = 1'b1; val = 2'd1;
    cycle("age_write");
    check("age_cleared", age, 4'd0);

    // Priority
    scan = 1'b1; write = 1'b1; enb = 1'b1; scan_in = 2'd1; val = 2'd2;
    cycle("pri_scan");
    check("pri_scan_s1", state, 2'd1);
    scan = 1'b0; max_state = 2'd3; val = 2'd3;
    cycle("pri_write");
    check("pri_write_s3", state, 2'd3);
    check("pri_write_chg", changed, 1'b0);
    max_state = 2'd2;
    cycle("ill_load");
    idle_ctl(); enb = 1'b1;
    cycle("ill_step");
    check("ill_step_s0", state, 2'd0);
    check("ill_step_chg", changed, 1'b1);

    // Async reset mid-cycle with a pending step
    idle_ctl(); max_state = 2'd1; survive_mask = 9'h1FF; write = 1'b1; val = 2'd1;
    cycle("ar_load");
    idle_ctl(); enb = 1'b1;
    for (int i = 0; i < 5; i++) cycle("ar_age");
    check("ar_age5", age, 4'd5);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_state", state, 2'd0);
    check("ar_age", age, 4'd0);
    check("ar_changed", changed, 1'b0);
    m_state = 2'd0; m_age = 4'd0; m_changed = 1'b0;
    @(posedge clk);
    #1;
    check("ar_held_state", state, 2'd0);
    @(negedge clk);
    enb = 1'b0;
    reset_n = 1'b1;
    cycle("ar_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
